csr_access_ctrl: RTL

//  Sequences every Zicsr instruction (CSRRW/CSRRS/CSRRC and immediate forms) issued by the EX stage.

---
 rtl/csr_access_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/csr_access_ctrl.sv
// Zicsr access sequencer: decodes CSR addresses, reads the cycle/instret counters,
// owns mscratch/mepc/mtvec and performs each read-modify-write as IDLE -> READ -> WRITE.
module csr_access_ctrl #(
    parameter logic [31:0] MTVEC_RESET    = 32'h0000_0000,
    parameter logic [31:0] MSCRATCH_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_addr,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_wdata,
    input  logic        req_wr_kill,
    input  logic        flush,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_illegal,
    output logic        cyc_r_en,
    output logic        cyc_r_pos,
    input  logic [31:0] cyc_rdata,
    output logic        inst_r_en,
    output logic        inst_r_pos,
    input  logic [31:0] inst_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_e;

    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;
    localparam logic [11:0] A_INSTRET  = 12'hC02;
    localparam logic [11:0] A_INSTRETH = 12'hC82;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MTVEC    = 12'h305;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    state_e      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] wdata_q, wdata_d;
    logic        kill_q, kill_d;
    logic [31:0] old_q, old_d;
    logic        illegal_q, illegal_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_illegal_q, rsp_illegal_d;

    logic        is_cyc, is_inst, is_ro, is_rw, wr_req, illegal_dec;
    logic        accept, commit;
    logic [31:0] read_val, new_val;

    // Decode of the latched request; valid throughout READ and WRITE.
    always_comb begin
        is_cyc      = (addr_q == A_CYCLE) || (addr_q == A_CYCLEH);
        is_inst     = (addr_q == A_INSTRET) || (addr_q == A_INSTRETH);
        is_ro       = is_cyc || is_inst;
        is_rw       = (addr_q == A_MSCRATCH) || (addr_q == A_MEPC) || (addr_q == A_MTVEC);
        wr_req      = (op_q == OP_RW) || !kill_q;
        illegal_dec = (op_q == 2'b00) || !(is_ro || is_rw) || (is_ro && wr_req);
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign cyc_r_en   = (state_q == S_READ) && is_cyc && !illegal_dec;
    assign cyc_r_pos  = cyc_r_en && addr_q[7];
    assign inst_r_en  = (state_q == S_READ) && is_inst && !illegal_dec;
    assign inst_r_pos = inst_r_en && addr_q[7];

    assign accept    = (state_q == S_IDLE) && req_valid && !flush;
    assign rsp_valid = (state_q == S_WRITE) && !flush;
    assign commit    = rsp_valid && !illegal_q && wr_req && is_rw;
    assign rsp_rdata   = rsp_valid ? old_q : rsp_rdata_q;
    assign rsp_illegal = rsp_valid ? illegal_q : rsp_illegal_q;

    always_comb begin
        read_val = 32'h0;
        if (!illegal_dec) begin
            case (addr_q)
                A_CYCLE, A_CYCLEH:     read_val = cyc_rdata;
                A_INSTRET, A_INSTRETH: read_val = inst_rdata;
                A_MSCRATCH:            read_val = mscratch_q;
                A_MEPC:                read_val = mepc_q;
                A_MTVEC:               read_val = mtvec_q;
                default:               read_val = 32'h0;
            endcase
        end
    end

    always_comb begin
        case (op_q)
            OP_RW:   new_val = wdata_q;
            OP_RS:   new_val = old_q | wdata_q;
            OP_RC:   new_val = old_q & ~wdata_q;
            default: new_val = old_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        op_d          = op_q;
        wdata_d       = wdata_q;
        kill_d        = kill_q;
        old_d         = old_q;
        illegal_d     = illegal_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mtvec_d       = mtvec_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_illegal_d = rsp_illegal_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_READ;
                    addr_d  = req_addr;
                    op_d    = req_op;
                    wdata_d = req_wdata;
                    kill_d  = req_wr_kill;
                end
            end
            S_READ: begin
                state_d   = flush ? S_IDLE : S_WRITE;
                old_d     = read_val;
                illegal_d = illegal_dec;
            end
            S_WRITE: begin
                state_d = S_IDLE;
                if (rsp_valid) begin
                    rsp_rdata_d   = old_q;
                    rsp_illegal_d = illegal_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // mepc is word aligned; mtvec bit 1 is fixed so only modes 0/1 exist.
        if (commit) begin
            case (addr_q)
                A_MSCRATCH: mscratch_d = new_val;
                A_MEPC:     mepc_d     = {new_val[31:2], 2'b00};
                A_MTVEC:    mtvec_d    = {new_val[31:2], 1'b0, new_val[0]};
                default:    mscratch_d = mscratch_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mscratch_q    <= MSCRATCH_RESET;
            mepc_q        <= 32'h0;
            mtvec_q       <= MTVEC_RESET;
            rsp_rdata_q   <= 32'h0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mtvec_q       <= mtvec_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    // Request operands are only meaningful while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        addr_q    <= addr_d;
        op_q      <= op_d;
        wdata_q   <= wdata_d;
        kill_q    <= kill_d;
        old_q     <= old_d;
        illegal_q <= illegal_d;
    end

endmodule
